pipe_hazard_ctrl: RTL and testbench

- Central stall/flush scheduler for the fetch-decode-execute-memory pipeline.
- Detects load-use hazards, execute-stage PC redirects, data-memory wait states and external stall/flush requests.
- Drives per-stage stall/flush lines and the execute bubble insert.
- Keeps saturating stall/flush statistics for the testbench.

---
 rtl/pipe_hazard_ctrl_if.sv | 51 +++++
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Port bundle for the pipeline hazard controller: pipeline status in, stall/flush controls out.
// Data-memory handshake: i_mem_req stays high while an access is outstanding; the access
// completes in the cycle i_mem_ack is high, and no stall is raised for that cycle.
interface pipe_hazard_ctrl_if #(
    parameter int AWIDTH    = 5,
    parameter int CNT_WIDTH = 16
);
    logic                 i_ce;
    logic                 i_stall;
    logic                 i_flush;
    logic [AWIDTH-1:0]    i_de_rs1_addr;
    logic [AWIDTH-1:0]    i_de_rs2_addr;
    logic                 i_de_rs1_used;
    logic                 i_de_rs2_used;
    logic                 i_ex_valid;
    logic                 i_ex_is_load;
    logic [AWIDTH-1:0]    i_ex_rd_addr;
    logic                 i_ex_change_pc;
    logic                 i_mem_req;
    logic                 i_mem_ack;
    logic                 o_fetch_stall;
    logic                 o_decode_stall;
    logic                 o_execute_stall;
    logic                 o_mem_stall;
    logic                 o_fetch_flush;
    logic                 o_decode_flush;
    logic                 o_execute_flush;
    logic                 o_bubble;
    logic [1:0]           o_state;
    logic                 o_timeout;
    logic [CNT_WIDTH-1:0] o_stall_cnt;
    logic [CNT_WIDTH-1:0] o_flush_cnt;

    modport master (
        output i_ce, i_stall, i_flush, i_de_rs1_addr, i_de_rs2_addr, i_de_rs1_used,
               i_de_rs2_used, i_ex_valid, i_ex_is_load, i_ex_rd_addr, i_ex_change_pc,
               i_mem_req, i_mem_ack,
        input  o_fetch_stall, o_decode_stall, o_execute_stall, o_mem_stall, o_fetch_flush,
               o_decode_flush, o_execute_flush, o_bubble, o_state, o_timeout,
               o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_ce, i_stall, i_flush, i_de_rs1_addr, i_de_rs2_addr, i_de_rs1_used,
               i_de_rs2_used, i_ex_valid, i_ex_is_load, i_ex_rd_addr, i_ex_change_pc,
               i_mem_req, i_mem_ack,
        output o_fetch_stall, o_decode_stall, o_execute_stall, o_mem_stall, o_fetch_flush,
               o_decode_flush, o_execute_flush, o_bubble, o_state, o_timeout,
               o_stall_cnt, o_flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler for the fetch-decode-execute-memory pipeline.
// Control outputs are Mealy; state, redirect/wait counters and statistics are registered.
module pipe_hazard_ctrl #(
    parameter int AWIDTH       = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15,
    parameter int CNT_WIDTH    = 16
) (
    input logic               fm_clk,
    input logic               fm_rst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam logic [3:0] RCNT_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [3:0]           rcnt_q, rcnt_d;
    logic [7:0]           wcnt_q, wcnt_d;
    logic                 timeout_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;
    logic [AWIDTH-1:0]    rd_addr;
    logic                 load_use, redirect_req;
    logic                 set_timeout, flush_evt;
    logic                 stall_all, lu_stall;
    logic                 fetch_flush, decode_flush, execute_flush;
    logic                 fetch_stall;

    assign rd_addr      = hz.i_ex_rd_addr;
    assign load_use     = hz.i_ex_valid && hz.i_ex_is_load && (rd_addr != '0) &&
                          ((hz.i_de_rs1_used && (hz.i_de_rs1_addr == rd_addr)) ||
                           (hz.i_de_rs2_used && (hz.i_de_rs2_addr == rd_addr)));
    assign redirect_req = hz.i_flush || hz.i_ex_change_pc;

    always_comb begin
        state_d       = state_q;
        rcnt_d        = rcnt_q;
        wcnt_d        = wcnt_q;
        set_timeout   = 1'b0;
        flush_evt     = 1'b0;
        stall_all     = 1'b0;
        lu_stall      = 1'b0;
        fetch_flush   = 1'b0;
        decode_flush  = 1'b0;
        execute_flush = 1'b0;
        if (!fm_rst) begin
            if (state_q == HALT || !hz.i_ce) begin
                stall_all = 1'b1;
            end else begin
                case (state_q)
                    RUN, REDIRECT: begin
                        // A branch retires itself, so only an external flush squashes execute.
                        if (redirect_req) begin
                            fetch_flush   = 1'b1;
                            decode_flush  = 1'b1;
                            execute_flush = hz.i_flush;
                            flush_evt     = 1'b1;
                            rcnt_d        = RCNT_INIT;
                            state_d       = (RCNT_INIT != 4'd0) ? REDIRECT : RUN;
                        end else if (state_q == REDIRECT) begin
                            fetch_flush = (rcnt_q != 4'd0);
                            rcnt_d      = (rcnt_q != 4'd0) ? rcnt_q - 4'd1 : 4'd0;
                            if (rcnt_q <= 4'd1) state_d = RUN;
                        end else if (hz.i_mem_req && !hz.i_mem_ack) begin
                            stall_all = 1'b1;
                            wcnt_d    = 8'd1;
                            state_d   = MEM_WAIT;
                        end else if (load_use) begin
                            lu_stall = 1'b1;
                        end else if (hz.i_stall) begin
                            stall_all = 1'b1;
                        end
                    end
                    MEM_WAIT: begin
                        if (hz.i_mem_ack) begin
                            wcnt_d  = 8'd0;
                            state_d = RUN;
                        end else begin
                            stall_all = 1'b1;
                            wcnt_d    = wcnt_q + 8'd1;
                            // Counter would reach the limit this edge: abort the access.
                            if (wcnt_q >= WAIT_LAST) begin
                                set_timeout   = 1'b1;
                                execute_flush = 1'b1;
                                wcnt_d        = 8'd0;
                                state_d       = HALT;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign fetch_stall = stall_all || lu_stall;

    always_ff @(posedge fm_clk) begin
        if (fm_rst) begin
            state_q     <= RUN;
            rcnt_q      <= 4'd0;
            wcnt_q      <= 8'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hz.i_ce) begin
                state_q <= state_d;
                rcnt_q  <= rcnt_d;
                wcnt_q  <= wcnt_d;
            end
            if (set_timeout) timeout_q <= 1'b1;
            if (fetch_stall && (hz.i_ce || state_q == HALT) && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            if (flush_evt && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign hz.o_fetch_stall   = fetch_stall;
    assign hz.o_decode_stall  = fetch_stall;
    assign hz.o_execute_stall = stall_all;
    assign hz.o_mem_stall     = stall_all;
    assign hz.o_fetch_flush   = fetch_flush;
    assign hz.o_decode_flush  = decode_flush;
    assign hz.o_execute_flush = execute_flush;
    assign hz.o_bubble        = lu_stall;
    assign hz.o_state         = state_q;
    assign hz.o_timeout       = timeout_q;
    assign hz.o_stall_cnt     = stall_cnt_q;
    assign hz.o_flush_cnt     = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a randomized run
// against an abstract cycle model of the stall/flush rules.
module tb_pipe_hazard_ctrl;
    localparam int AWIDTH       = 5;
    localparam int FLUSH_CYCLES = 2;
    localparam int MEM_TIMEOUT  = 15;
    localparam int CNT_WIDTH    = 16;

    // Control vector order: {fs, ds, es, ms, ff, df, ef, bubble}
    localparam logic [7:0] ALL_STALL = 8'hF0;
    localparam logic [7:0] LU_STALL  = 8'hC1;
    localparam logic [7:0] FLUSH_ALL = 8'h0E;
    localparam logic [7:0] FLUSH_PC  = 8'h0C;
    localparam logic [7:0] FETCH_FL  = 8'h08;
    localparam logic [7:0] EX_FL     = 8'h02;

    logic fm_clk = 1'b0;
    logic fm_rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    int   m_wait, m_redir, m_stall_cnt, m_flush_cnt;
    bit   m_halt, m_timeout;

    pipe_hazard_ctrl_if #(.AWIDTH(AWIDTH), .CNT_WIDTH(CNT_WIDTH)) hz ();

    pipe_hazard_ctrl #(
        .AWIDTH(AWIDTH), .FLUSH_CYCLES(FLUSH_CYCLES),
        .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .fm_clk(fm_clk),
        .fm_rst(fm_rst),
        .hz(hz)
    );

    always #5 fm_clk = ~fm_clk;

    function automatic logic [7:0] outs();
        return {hz.o_fetch_stall, hz.o_decode_stall, hz.o_execute_stall, hz.o_mem_stall,
                hz.o_fetch_flush, hz.o_decode_flush, hz.o_execute_flush, hz.o_bubble};
    endfunction

    task automatic tick();
        @(posedge fm_clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.i_ce = 1'b1;           hz.i_stall = 1'b0;       hz.i_flush = 1'b0;
        hz.i_de_rs1_addr = '0;    hz.i_de_rs2_addr = '0;
        hz.i_de_rs1_used = 1'b0;  hz.i_de_rs2_used = 1'b0;
        hz.i_ex_valid = 1'b0;     hz.i_ex_is_load = 1'b0;  hz.i_ex_rd_addr = '0;
        hz.i_ex_change_pc = 1'b0; hz.i_mem_req = 1'b0;     hz.i_mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        fm_rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        fm_rst = 1'b0;
    endtask

    // Abstract model: outstanding wait age, remaining fetch-flush cycles, halted flag.
    task automatic model_cycle(output logic [7:0] e);
        bit lu;
        e  = 8'h00;
        lu = hz.i_ex_valid && hz.i_ex_is_load && (hz.i_ex_rd_addr != 0) &&
             ((hz.i_de_rs1_used && hz.i_de_rs1_addr == hz.i_ex_rd_addr) ||
              (hz.i_de_rs2_used && hz.i_de_rs2_addr == hz.i_ex_rd_addr));
        if (m_halt || !hz.i_ce) begin
            e = ALL_STALL;
        end else if (m_wait > 0) begin
            if (hz.i_mem_ack) begin
                m_wait = 0;
            end else begin
                e = ALL_STALL;
                m_wait = m_wait + 1;
                if (m_wait >= MEM_TIMEOUT) begin
                    e = ALL_STALL | EX_FL;
                    m_timeout = 1;
                    m_halt = 1;
                    m_wait = 0;
                end
            end
        end else if (hz.i_flush || hz.i_ex_change_pc) begin
            e = hz.i_flush ? FLUSH_ALL : FLUSH_PC;
            m_redir = FLUSH_CYCLES - 1;
            if (m_flush_cnt < 65535) m_flush_cnt = m_flush_cnt + 1;
        end else if (m_redir > 0) begin
            e = FETCH_FL;
            m_redir = m_redir - 1;
        end else if (hz.i_mem_req && !hz.i_mem_ack) begin
            e = ALL_STALL;
            m_wait = 1;
        end else if (lu) begin
            e = LU_STALL;
        end else if (hz.i_stall) begin
            e = ALL_STALL;
        end
        if (e[7] && (hz.i_ce || m_halt) && m_stall_cnt < 65535) m_stall_cnt = m_stall_cnt + 1;
    endtask

    task automatic test_reset();
        fm_rst = 1'b1;
        clear_inputs();
        hz.i_stall = 1'b1; hz.i_flush = 1'b1; hz.i_mem_req = 1'b1;
        #1;
        n_checks++;
        if (outs() !== 8'h00) begin n_fails++; $display("FAIL reset_forced: got %h expected 00", outs()); end
        do_reset();
        #1;
        n_checks++;
        if (outs() !== 8'h00) begin n_fails++; $display("FAIL idle_outs: got %h expected 00", outs()); end
        n_checks++;
        if ({hz.o_state, hz.o_timeout, hz.o_stall_cnt, hz.o_flush_cnt} !== 35'd0) begin
            n_fails++;
            $display("FAIL reset_regs: got state %0d to %0d sc %0d fc %0d expected all 0",
                     hz.o_state, hz.o_timeout, hz.o_stall_cnt, hz.o_flush_cnt);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        hz.i_ex_valid = 1'b1; hz.i_ex_is_load = 1'b1; hz.i_ex_rd_addr = 5'd5;
        hz.i_de_rs2_addr = 5'd5; hz.i_de_rs2_used = 1'b1; hz.i_de_rs1_addr = 5'd3;
        #1;
        n_checks++;
        if (outs() !== LU_STALL) begin n_fails++; $display("FAIL load_use: got %h expected %h", outs(), LU_STALL); end
        tick();
        hz.i_ex_valid = 1'b0;
        #1;
        n_checks++;
        if (outs() !== 8'h00 || hz.o_state !== 2'd0) begin
            n_fails++; $display("FAIL load_use_after: got %h/%0d expected 00/0", outs(), hz.o_state);
        end
        hz.i_ex_valid = 1'b1; hz.i_ex_rd_addr = 5'd0; hz.i_de_rs2_addr = 5'd0;
        #1;
        n_checks++;
        if (outs() !== 8'h00) begin n_fails++; $display("FAIL load_use_rd0: got %h expected 00", outs()); end
        hz.i_ex_rd_addr = 5'd9; hz.i_de_rs1_addr = 5'd9; hz.i_de_rs1_used = 1'b1; hz.i_de_rs2_used = 1'b0;
        #1;
        n_checks++;
        if (outs() !== LU_STALL) begin n_fails++; $display("FAIL load_use_rs1: got %h expected %h", outs(), LU_STALL); end
        tick();
        n_checks++;
        if (hz.o_stall_cnt !== 16'd2) begin n_fails++; $display("FAIL load_use_cnt: got %0d expected 2", hz.o_stall_cnt); end
        clear_inputs();
    endtask

    task automatic test_branch();
        do_reset();
        hz.i_ex_change_pc = 1'b1;
        #1;
        n_checks++;
        if (outs() !== FLUSH_PC) begin n_fails++; $display("FAIL branch_c0: got %h expected %h", outs(), FLUSH_PC); end
        tick();
        hz.i_ex_change_pc = 1'b0;
        #1;
        n_checks++;
        if (outs() !== FETCH_FL || hz.o_state !== 2'd2) begin
            n_fails++; $display("FAIL branch_c1: got %h/%0d expected %h/2", outs(), hz.o_state, FETCH_FL);
        end
        tick();
        n_checks++;
        if (outs() !== 8'h00 || hz.o_state !== 2'd0 || hz.o_flush_cnt !== 16'd1) begin
            n_fails++;
            $display("FAIL branch_c2: got %h/%0d/%0d expected 00/0/1", outs(), hz.o_state, hz.o_flush_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        hz.i_ex_change_pc = 1'b1;
        tick();
        hz.i_ex_change_pc = 1'b0; hz.i_flush = 1'b1;
        #1;
        n_checks++;
        if (outs() !== FLUSH_ALL) begin n_fails++; $display("FAIL restart_outs: got %h expected %h", outs(), FLUSH_ALL); end
        tick();
        hz.i_flush = 1'b0;
        #1;
        n_checks++;
        if (hz.o_state !== 2'd2 || hz.o_flush_cnt !== 16'd2 || outs() !== FETCH_FL) begin
            n_fails++;
            $display("FAIL restart_state: got %0d/%0d/%h expected 2/2/%h", hz.o_state, hz.o_flush_cnt, outs(), FETCH_FL);
        end
        tick();
        n_checks++;
        if (hz.o_state !== 2'd0) begin n_fails++; $display("FAIL restart_end: got %0d expected 0", hz.o_state); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        hz.i_mem_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++;
            if (outs() !== ALL_STALL) begin n_fails++; $display("FAIL mem_wait_c%0d: got %h expected %h", c, outs(), ALL_STALL); end
            tick();
        end
        hz.i_mem_ack = 1'b1;
        #1;
        n_checks++;
        if (outs() !== 8'h00 || hz.o_state !== 2'd1) begin
            n_fails++; $display("FAIL mem_ack: got %h/%0d expected 00/1", outs(), hz.o_state);
        end
        tick();
        n_checks++;
        if (hz.o_state !== 2'd0 || hz.o_stall_cnt !== 16'd4) begin
            n_fails++; $display("FAIL mem_release: got %0d/%0d expected 0/4", hz.o_state, hz.o_stall_cnt);
        end
        #1;
        n_checks++;
        if (outs() !== 8'h00) begin n_fails++; $display("FAIL mem_same_ack: got %h expected 00", outs()); end
        tick();
        n_checks++;
        if (hz.o_state !== 2'd0 || hz.o_stall_cnt !== 16'd4) begin
            n_fails++; $display("FAIL mem_same_ack_regs: got %0d/%0d expected 0/4", hz.o_state, hz.o_stall_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        hz.i_mem_req = 1'b1;
        for (int c = 0; c < MEM_TIMEOUT; c++) begin
            #1;
            n_checks++;
            if (outs() !== ((c == MEM_TIMEOUT - 1) ? (ALL_STALL | EX_FL) : ALL_STALL)) begin
                n_fails++; $display("FAIL timeout_c%0d: got %h", c, outs());
            end
            tick();
        end
        n_checks++;
        if (hz.o_state !== 2'd3 || hz.o_timeout !== 1'b1 || hz.o_stall_cnt !== 16'd15) begin
            n_fails++;
            $display("FAIL timeout_halt: got %0d/%0d/%0d expected 3/1/15", hz.o_state, hz.o_timeout, hz.o_stall_cnt);
        end
        hz.i_mem_req = 1'b0; hz.i_mem_ack = 1'b1;
        #1;
        n_checks++;
        if (outs() !== ALL_STALL) begin n_fails++; $display("FAIL halt_stall: got %h expected %h", outs(), ALL_STALL); end
        tick();
        n_checks++;
        if (hz.o_state !== 2'd3 || hz.o_stall_cnt !== 16'd16) begin
            n_fails++; $display("FAIL halt_hold: got %0d/%0d expected 3/16", hz.o_state, hz.o_stall_cnt);
        end
        do_reset();
        n_checks++;
        if ({hz.o_state, hz.o_timeout, hz.o_stall_cnt} !== 19'd0) begin
            n_fails++; $display("FAIL halt_reset: got %0d/%0d/%0d expected 0/0/0", hz.o_state, hz.o_timeout, hz.o_stall_cnt);
        end
    endtask

    task automatic test_ce();
        do_reset();
        hz.i_ce = 1'b0; hz.i_flush = 1'b1; hz.i_mem_req = 1'b1;
        #1;
        n_checks++;
        if (outs() !== ALL_STALL) begin n_fails++; $display("FAIL ce_outs: got %h expected %h", outs(), ALL_STALL); end
        tick();
        n_checks++;
        if (hz.o_state !== 2'd0 || hz.o_flush_cnt !== 16'd0 || hz.o_stall_cnt !== 16'd0) begin
            n_fails++;
            $display("FAIL ce_hold: got %0d/%0d/%0d expected 0/0/0", hz.o_state, hz.o_flush_cnt, hz.o_stall_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        do_reset();
        hz.i_flush = 1'b1; hz.i_ex_change_pc = 1'b1; hz.i_mem_req = 1'b1; hz.i_stall = 1'b1;
        hz.i_ex_valid = 1'b1; hz.i_ex_is_load = 1'b1; hz.i_ex_rd_addr = 5'd7;
        hz.i_de_rs1_addr = 5'd7; hz.i_de_rs1_used = 1'b1;
        #1;
        n_checks++;
        if (outs() !== FLUSH_ALL) begin n_fails++; $display("FAIL prio_outs: got %h expected %h", outs(), FLUSH_ALL); end
        tick();
        n_checks++;
        if (hz.o_state !== 2'd2 || hz.o_flush_cnt !== 16'd1) begin
            n_fails++; $display("FAIL prio_state: got %0d/%0d expected 2/1", hz.o_state, hz.o_flush_cnt);
        end
        clear_inputs();
        tick();
        hz.i_mem_req = 1'b1;
        tick();
        n_checks++;
        if (hz.o_state !== 2'd1) begin n_fails++; $display("FAIL prio_memwait: got %0d expected 1", hz.o_state); end
        fm_rst = 1'b1;
        #1;
        n_checks++;
        if (outs() !== 8'h00) begin n_fails++; $display("FAIL rst_mid_wait_outs: got %h expected 00", outs()); end
        tick();
        n_checks++;
        if (hz.o_state !== 2'd0) begin n_fails++; $display("FAIL rst_mid_wait: got %0d expected 0", hz.o_state); end
        fm_rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_random();
        logic [7:0]  exp_o;
        logic [34:0] exp_r;
        for (int chunk = 0; chunk < 6; chunk++) begin
            do_reset();
            m_wait = 0; m_redir = 0; m_stall_cnt = 0; m_flush_cnt = 0; m_halt = 0; m_timeout = 0;
            for (int c = 0; c < 60; c++) begin
                hz.i_ce           = ($urandom_range(0, 7) != 0);
                hz.i_stall        = ($urandom_range(0, 5) == 0);
                hz.i_flush        = ($urandom_range(0, 11) == 0);
                hz.i_ex_change_pc = ($urandom_range(0, 7) == 0);
                hz.i_mem_req      = ($urandom_range(0, 3) == 0);
                hz.i_mem_ack      = ($urandom_range(0, 2) == 0);
                hz.i_ex_valid     = ($urandom_range(0, 1) == 1);
                hz.i_ex_is_load   = ($urandom_range(0, 1) == 1);
                hz.i_de_rs1_used  = ($urandom_range(0, 1) == 1);
                hz.i_de_rs2_used  = ($urandom_range(0, 1) == 1);
                hz.i_ex_rd_addr   = AWIDTH'($urandom_range(0, 3));
                hz.i_de_rs1_addr  = AWIDTH'($urandom_range(0, 3));
                hz.i_de_rs2_addr  = AWIDTH'($urandom_range(0, 3));
                #1;
                model_cycle(exp_o);
                n_checks++;
                if (outs() !== exp_o) begin
                    n_fails++; $display("FAIL rand_outs chunk %0d cycle %0d: got %h expected %h", chunk, c, outs(), exp_o);
                end
                tick();
                exp_r = {(m_halt ? 2'd3 : (m_wait > 0) ? 2'd1 : (m_redir > 0) ? 2'd2 : 2'd0),
                         m_timeout, 16'(m_stall_cnt), 16'(m_flush_cnt)};
                n_checks++;
                if ({hz.o_state, hz.o_timeout, hz.o_stall_cnt, hz.o_flush_cnt} !== exp_r) begin
                    n_fails++;
                    $display("FAIL rand_regs chunk %0d cycle %0d: got %h expected %h", chunk, c,
                             {hz.o_state, hz.o_timeout, hz.o_stall_cnt, hz.o_flush_cnt}, exp_r);
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_back_to_back();
        test_mem_wait();
        test_timeout();
        test_ce();
        test_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
